motor_speed_sequencer: RTL and testbench

- Closed-loop speed and direction sequencer placed in front of the motor controller.
- Drives its duty-cycle and direction-request inputs from a software target speed and direction, and reads back its feedback RPS.
- Regulates duty with a clamped incremental controller at a fixed update rate.
- Sequences direction reversals as brake, wait-for-stop, swap, dwell, resume, so the H-bridge never reverses under drive.

---
 rtl/motor_speed_sequencer_pkg.sv | 22 ++
 rtl/motor_speed_sequencer_speed_step_calc.sv | 69 ++++++
 rtl/motor_speed_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_motor_speed_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_speed_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// motor_speed_sequencer_pkg
// Shared types and widths for the motor speed/direction sequencer.
//   state_e  : sequencer states (IDLE, RUN, BRAKE, SWAP)
//   DUTY_W   : duty-cycle width driven to the motor controller
//   RPS_W    : width of target and feedback speeds
//   DUTY_MAX : saturation ceiling for the duty cycle
// -----------------------------------------------------------------------------
package motor_speed_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2,
        ST_SWAP  = 2'd3
    } state_e;

    localparam int DUTY_W = 8;
    localparam int RPS_W  = 16;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

endpackage

// File: rtl/motor_speed_sequencer_speed_step_calc.sv
// -----------------------------------------------------------------------------
// speed_step_calc
// Combinational regulation step: signed speed error, clamped proportional
// step and saturating duty update. Used by the sequencer on update ticks.
//   target_rps_i : synchronised target speed
//   fb_rps_i     : registered feedback speed
//   duty_i       : current duty
//   duty_o       : duty to load if this is an update tick
//   in_band_o    : |error| <= DEADBAND
// -----------------------------------------------------------------------------
module speed_step_calc
    import motor_speed_sequencer_pkg::*;
#(
    parameter int DEADBAND   = 1,
    parameter int GAIN_SHIFT = 2,
    parameter int MAX_STEP   = 16
) (
    input  logic [RPS_W-1:0]  target_rps_i,
    input  logic [RPS_W-1:0]  fb_rps_i,
    input  logic [DUTY_W-1:0] duty_i,
    output logic [DUTY_W-1:0] duty_o,
    output logic              in_band_o
);

    localparam logic signed [RPS_W:0] DB_POS     = (RPS_W+1)'(DEADBAND);
    localparam logic signed [RPS_W:0] DB_NEG     = (RPS_W+1)'(-DEADBAND);
    localparam logic [RPS_W:0]        MAX_STEP_W = (RPS_W+1)'(MAX_STEP);
    localparam logic [DUTY_W-1:0]     MAX_STEP_D = DUTY_W'(MAX_STEP);

    logic signed [RPS_W:0] err;
    logic [RPS_W:0]        mag;
    logic [RPS_W:0]        shifted;
    logic [DUTY_W-1:0]     step;
    logic [DUTY_W:0]       sum;
    logic                  err_pos;
    logic                  err_neg;

    always_comb begin
        // 17-bit signed difference so the full 16-bit range never overflows.
        err     = $signed({1'b0, target_rps_i}) - $signed({1'b0, fb_rps_i});
        mag     = err[RPS_W] ? $unsigned(-err) : $unsigned(err);
        shifted = mag >> GAIN_SHIFT;

        // Step is at least 1 so small errors outside the deadband still move.
        if (shifted > MAX_STEP_W) begin
            step = MAX_STEP_D;
        end else if (shifted == '0) begin
            step = DUTY_W'(1);
        end else begin
            step = shifted[DUTY_W-1:0];
        end

        err_pos = (err > DB_POS);
        err_neg = (err < DB_NEG);

        // 9-bit sum: the carry bit is the saturation indicator.
        sum = {1'b0, duty_i} + {1'b0, step};

        duty_o = duty_i;
        if (err_pos) begin
            duty_o = sum[DUTY_W] ? DUTY_MAX : sum[DUTY_W-1:0];
        end else if (err_neg) begin
            duty_o = (step > duty_i) ? '0 : (duty_i - step);
        end

        in_band_o = !err_pos && !err_neg;
    end

endmodule

// File: rtl/motor_speed_sequencer.sv
// -----------------------------------------------------------------------------
// motor_speed_sequencer
// Closed-loop speed regulation and safe direction reversal in front of the
// motor controller. Reversals go RUN -> BRAKE -> SWAP (dwell) -> RUN so the
// H-bridge never flips direction while driven.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   enable_i     : 1 = regulate, 0 = duty 0 and return to IDLE
//   target_rps_i : requested speed (RPS)
//   target_dir_i : requested direction, 1 = CW
//   fb_rps_i     : measured speed from the motor controller
//   duty_o       : duty cycle 0..255
//   dir_o        : direction request
//   at_speed_o   : in RUN with |error| <= DEADBAND at the last update
//   busy_o       : in BRAKE or SWAP
//   brake_to_o   : sticky brake-timeout flag, cleared while disabled
//   state_o      : current FSM state (debug)
//
// Handshake note: there is no valid/ready traffic here; every input is a
// level that is synchronised and sampled, every output is a registered level.
// -----------------------------------------------------------------------------
module motor_speed_sequencer
    import motor_speed_sequencer_pkg::*;
#(
    parameter int UPDATE_CYCLES = 6250000,
    parameter int DEADBAND      = 1,
    parameter int GAIN_SHIFT    = 2,
    parameter int MAX_STEP      = 16,
    parameter int STOP_RPS      = 1,
    parameter int BRAKE_TIMEOUT = 32,
    parameter int DWELL_TICKS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [RPS_W-1:0]  target_rps_i,
    input  logic              target_dir_i,
    input  logic [RPS_W-1:0]  fb_rps_i,
    output logic [DUTY_W-1:0] duty_o,
    output logic              dir_o,
    output logic              at_speed_o,
    output logic              busy_o,
    output logic              brake_to_o,
    output state_e            state_o
);

    localparam int CNT_W = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_CYCLES - 1);
    localparam int AUX_MAX = (BRAKE_TIMEOUT > DWELL_TICKS) ? BRAKE_TIMEOUT : DWELL_TICKS;
    localparam int AUX_W = $clog2(AUX_MAX) + 1;
    localparam logic [AUX_W-1:0] BRK_LAST   = AUX_W'(BRAKE_TIMEOUT - 1);
    localparam logic [AUX_W-1:0] DWELL_LAST = AUX_W'(DWELL_TICKS - 1);
    localparam logic [RPS_W-1:0] STOP_W     = RPS_W'(STOP_RPS);

    // Synchronisers and feedback register
    logic             en_s1_q, en_s2_q;
    logic             dir_s1_q, dir_s2_q;
    logic [RPS_W-1:0] rps_s1_q, rps_s2_q;
    logic [RPS_W-1:0] fb_q;

    // Sequencer state
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AUX_W-1:0]  aux_q, aux_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d;
    logic              at_speed_q, at_speed_d;
    logic              brake_to_q, brake_to_d;

    logic              tick;
    logic [DUTY_W-1:0] calc_duty;
    logic              calc_in_band;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1_q  <= 1'b0;
            en_s2_q  <= 1'b0;
            dir_s1_q <= 1'b0;
            dir_s2_q <= 1'b0;
            rps_s1_q <= '0;
            rps_s2_q <= '0;
            fb_q     <= '0;
        end else begin
            en_s1_q  <= enable_i;
            en_s2_q  <= en_s1_q;
            dir_s1_q <= target_dir_i;
            dir_s2_q <= dir_s1_q;
            rps_s1_q <= target_rps_i;
            rps_s2_q <= rps_s1_q;
            fb_q     <= fb_rps_i;
        end
    end

    speed_step_calc #(
        .DEADBAND   (DEADBAND),
        .GAIN_SHIFT (GAIN_SHIFT),
        .MAX_STEP   (MAX_STEP)
    ) u_step (
        .target_rps_i (rps_s2_q),
        .fb_rps_i     (fb_q),
        .duty_i       (duty_q),
        .duty_o       (calc_duty),
        .in_band_o    (calc_in_band)
    );

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        at_speed_d = at_speed_q;
        brake_to_d = brake_to_q;
        aux_d      = aux_q;

        if (!en_s2_q) begin
            state_d    = ST_IDLE;
            duty_d     = '0;
            at_speed_d = 1'b0;
            brake_to_d = 1'b0;
            if (state_q == ST_IDLE) begin
                dir_d = dir_s2_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    duty_d     = '0;
                    at_speed_d = 1'b0;
                    dir_d      = dir_s2_q;
                    state_d    = ST_RUN;
                end
                ST_RUN: begin
                    if (dir_s2_q != dir_q) begin
                        // Drive is removed on the same edge BRAKE is entered.
                        state_d    = ST_BRAKE;
                        duty_d     = '0;
                        at_speed_d = 1'b0;
                    end else if (tick) begin
                        duty_d     = calc_duty;
                        at_speed_d = calc_in_band;
                    end
                end
                ST_BRAKE: begin
                    duty_d     = '0;
                    at_speed_d = 1'b0;
                    if (tick) begin
                        if (fb_q <= STOP_W) begin
                            state_d = ST_SWAP;
                            dir_d   = dir_s2_q;
                        end else if (aux_q == BRK_LAST) begin
                            state_d    = ST_SWAP;
                            dir_d      = dir_s2_q;
                            brake_to_d = 1'b1;
                        end else begin
                            aux_d = aux_q + 1'b1;
                        end
                    end
                end
                ST_SWAP: begin
                    duty_d     = '0;
                    at_speed_d = 1'b0;
                    if (tick) begin
                        if (aux_q == DWELL_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            aux_d = aux_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                end
            endcase
        end

        // Timer and tick-count restart on every state change so the first
        // update in a new state is a full period after entry.
        if (state_d != state_q) begin
            aux_d = '0;
        end
        cnt_d = ((state_d != state_q) || tick) ? '0 : (cnt_q + 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            aux_q      <= '0;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            at_speed_q <= 1'b0;
            brake_to_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aux_q      <= aux_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            at_speed_q <= at_speed_d;
            brake_to_q <= brake_to_d;
        end
    end

    assign duty_o     = duty_q;
    assign dir_o      = dir_q;
    assign at_speed_o = at_speed_q;
    assign brake_to_o = brake_to_q;
    assign busy_o     = (state_q == ST_BRAKE) || (state_q == ST_SWAP);
    assign state_o    = state_q;

endmodule

// File: tb/tb_motor_speed_sequencer.sv
// -----------------------------------------------------------------------------
// tb_motor_speed_sequencer
// Directed bench for motor_speed_sequencer with a short update period.
// -----------------------------------------------------------------------------
module tb_motor_speed_sequencer;
    import motor_speed_sequencer_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] target_rps;
    logic        target_dir;
    logic [15:0] fb_rps;
    logic [7:0]  duty;
    logic        dir;
    logic        at_speed;
    logic        busy;
    logic        brake_to;
    state_e      state;

    always #5 clk = ~clk;

    motor_speed_sequencer #(
        .UPDATE_CYCLES (16),
        .DEADBAND      (1),
        .GAIN_SHIFT    (2),
        .MAX_STEP      (16),
        .STOP_RPS      (1),
        .BRAKE_TIMEOUT (32),
        .DWELL_TICKS   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .target_rps_i (target_rps),
        .target_dir_i (target_dir),
        .fb_rps_i     (fb_rps),
        .duty_o       (duty),
        .dir_o        (dir),
        .at_speed_o   (at_speed),
        .busy_o       (busy),
        .brake_to_o   (brake_to),
        .state_o      (state)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $error("FAIL %s: observed %0d with no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_mis++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [15:0] obs, input logic [15:0] v);
        push(v);
        check(tag, obs);
    endtask

    // ---------------- driver helpers ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_duty_change(input int budget);
        logic [7:0] prev;
        bit         seen;
        prev = duty;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (duty !== prev) seen = 1'b1;
        end
    endtask

    task automatic wait_state(input state_e s, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (state == s) break;
        end
    endtask

    task automatic ramp_to(input string tag, input int step, input int last);
        int cnt;
        cnt = 0;
        for (int v = step; v <= last; v += step) begin
            push(16'(v));
            cnt++;
        end
        for (int k = 0; k < cnt; k++) begin
            wait_duty_change(40);
            check(tag, {8'h00, duty});
        end
    endtask

    // ---------------- directed sequence ----------------
    int n;

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        target_rps = 16'd0;
        target_dir = 1'b0;
        fb_rps     = 16'd0;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);

        // Reset / idle
        expect_now("rst_duty",     {8'h00, duty},  16'd0);
        expect_now("rst_dir",      16'(dir),       16'd0);
        expect_now("rst_busy",     16'(busy),      16'd0);
        expect_now("rst_brake_to", 16'(brake_to),  16'd0);
        expect_now("rst_state",    16'(state),     16'(ST_IDLE));

        target_dir = 1'b1;
        cycles(3);
        expect_now("idle_dir_follow", 16'(dir), 16'd1);

        // Spin-up: step 10 per tick, saturating at 255
        target_rps = 16'd40;
        fb_rps     = 16'd0;
        enable     = 1'b1;
        ramp_to("spin_duty", 10, 250);
        push(16'd255);
        wait_duty_change(40);
        check("spin_sat", {8'h00, duty});
        cycles(40);
        expect_now("spin_no_wrap",  {8'h00, duty}, 16'd255);
        expect_now("spin_not_at",   16'(at_speed), 16'd0);
        fb_rps = 16'd40;
        cycles(40);
        expect_now("hold_duty",     {8'h00, duty}, 16'd255);
        expect_now("hold_at_speed", 16'(at_speed), 16'd1);

        // Overspeed: climb to 100, then step clamps at 16 down to 0
        enable = 1'b0;
        cycles(4);
        expect_now("dis_duty",  {8'h00, duty},  16'd0);
        expect_now("dis_state", 16'(state),     16'(ST_IDLE));
        fb_rps = 16'd0;
        enable = 1'b1;
        ramp_to("pre_over", 10, 100);
        target_rps = 16'd10;
        fb_rps     = 16'd200;
        for (int v = 84; v >= 4; v -= 16) push(16'(v));
        push(16'd0);
        for (int k = 0; k < 7; k++) begin
            wait_duty_change(40);
            check("over_duty", {8'h00, duty});
        end
        cycles(40);
        expect_now("over_floor",   {8'h00, duty}, 16'd0);
        expect_now("over_at_speed", 16'(at_speed), 16'd0);

        // Reversal with feedback already stopped
        target_rps = 16'd40;
        fb_rps     = 16'd0;
        ramp_to("pre_rev", 10, 120);
        target_dir = 1'b0;
        wait_state(ST_BRAKE, 10, n);
        expect_now("rev_brake_lat", 16'(n),        16'd3);
        expect_now("rev_busy",      16'(busy),     16'd1);
        expect_now("rev_duty0",     {8'h00, duty}, 16'd0);
        expect_now("rev_dir_hold",  16'(dir),      16'd1);
        wait_state(ST_SWAP, 40, n);
        expect_now("rev_swap_lat",  16'(n),        16'd16);
        expect_now("rev_dir_new",   16'(dir),      16'd0);
        expect_now("rev_swap_busy", 16'(busy),     16'd1);
        expect_now("rev_no_to",     16'(brake_to), 16'd0);
        wait_state(ST_RUN, 100, n);
        expect_now("rev_dwell",     16'(n),        16'd64);
        expect_now("rev_run_duty",  {8'h00, duty}, 16'd0);
        expect_now("rev_run_busy",  16'(busy),     16'd0);
        push(16'd10);
        wait_duty_change(40);
        check("rev_restart", {8'h00, duty});

        // Brake timeout with the motor still spinning
        fb_rps     = 16'd50;
        target_dir = 1'b1;
        wait_state(ST_BRAKE, 10, n);
        expect_now("to_brake_lat", 16'(n), 16'd3);
        wait_state(ST_SWAP, 600, n);
        expect_now("to_cycles",    16'(n),        16'd512);
        expect_now("to_flag",      16'(brake_to), 16'd1);
        expect_now("to_dir",       16'(dir),      16'd1);
        expect_now("to_busy",      16'(busy),     16'd1);
        enable = 1'b0;
        cycles(3);
        expect_now("to_clr_state", 16'(state),    16'(ST_IDLE));
        expect_now("to_clr_flag",  16'(brake_to), 16'd0);
        expect_now("to_clr_duty",  {8'h00, duty}, 16'd0);

        // Async reset mid-run at duty 200
        fb_rps     = 16'd0;
        target_rps = 16'd40;
        enable     = 1'b1;
        ramp_to("pre_rst", 10, 200);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        expect_now("arst_duty",  {8'h00, duty}, 16'd0);
        expect_now("arst_state", 16'(state),    16'(ST_IDLE));
        expect_now("arst_dir",   16'(dir),      16'd0);
        expect_now("arst_busy",  16'(busy),     16'd0);
        enable = 1'b0;
        #10;
        rst_n = 1'b1;
        cycles(3);
        expect_now("arst_rel_state", 16'(state),    16'(ST_IDLE));
        expect_now("arst_rel_duty",  {8'h00, duty}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
